// File: rtl/bf_membus_pkg.sv
// Shared definitions for the BrainFuzz ROM/RAM bus controller: FSM encoding,
// requester port IDs and the legal wait-state range.
package bf_membus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;

  // Wait-state counter load value; out-of-range settings are clamped so the
  // 4-bit counter can never wrap.
  function automatic logic [3:0] wait_load(input int wait_cycles);
    int w;
    w = wait_cycles;
    if (w < WAIT_MIN) w = WAIT_MIN;
    if (w > WAIT_MAX) w = WAIT_MAX;
    return 4'(w - 1);
  endfunction

endpackage

// File: rtl/bf_mem_bus_ctrl_if.sv
// Request/acknowledge bundle between the interpreter core (master) and the
// bus controller (slave): one ROM fetch port and one RAM data port.
interface bf_mem_bus_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ack;
  logic [DATA_W-1:0] fetch_rdata;

  logic              data_req;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_ack;
  logic [DATA_W-1:0] data_rdata;

  modport master (
    output fetch_req, fetch_addr,
    output data_req, data_we, data_addr, data_wdata,
    input  fetch_ack, fetch_rdata, data_ack, data_rdata
  );

  modport slave (
    input  fetch_req, fetch_addr,
    input  data_req, data_we, data_addr, data_wdata,
    output fetch_ack, fetch_rdata, data_ack, data_rdata
  );

endinterface

// File: rtl/bf_membus_arb.sv
// Two-requester arbiter for the bus controller.
// Optional feature macro: MEMBUS_ROUND_ROBIN_EN (round-robin on ties);
// without it, data always wins over fetch and no pointer flop exists.
module bf_membus_arb
  import bf_membus_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic fetch_req,
  input  logic data_req,
  input  logic grant_en,
  output logic grant,
  output logic port_id
);

  assign grant = grant_en && (fetch_req || data_req);

`ifdef MEMBUS_ROUND_ROBIN_EN
  logic prio;

  // Tie-break pointer: after every grant the other port becomes favoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= PORT_DATA;
    end else if (grant) begin
      prio <= ~port_id;
    end
  end

  // Winner selection: the pointer only matters when both ports request.
  always_comb begin
    port_id = PORT_FETCH;
    if (fetch_req && data_req) begin
      port_id = prio;
    end else if (data_req) begin
      port_id = PORT_DATA;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign port_id        = data_req ? PORT_DATA : PORT_FETCH;
`endif

endmodule

// File: rtl/bf_mem_bus_ctrl.sv
// Bus controller between the BrainFuzz core and the shared ROM/RAM chip bus.
// Sequences active-low chip strobes and the shared tri-state data bus from
// request/ack handshakes. Arbitration mode selected by MEMBUS_ROUND_ROBIN_EN
// (handled inside bf_membus_arb).
//
// state  | meaning
// IDLE   | waiting for a request; arbiter grants and request fields are latched
// SETUP  | address valid, strobes high; write data starts driving
// ACCESS | strobes low for WAIT_CYCLES cycles; read data captured on last edge
// DONE   | strobes high, ack to granted port; write data/address held
module bf_mem_bus_ctrl
  import bf_membus_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  bf_mem_bus_ctrl_if.slave  bus,
  output logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data,
  output logic              ROM_CEb,
  output logic              RAM_CEb,
  output logic              RAM_WEb,
  output logic              RAM_OEb
);

  localparam logic [3:0] CNT_LOAD = wait_load(WAIT_CYCLES);

  state_t            state;
  state_t            state_next;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_port;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] fetch_rdata_q;
  logic [DATA_W-1:0] data_rdata_q;
  logic              grant;
  logic              grant_port;
  logic              access_last;
  logic              data_oe;

  bf_membus_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .fetch_req (bus.fetch_req),
    .data_req  (bus.data_req),
    .grant_en  (state == ST_IDLE),
    .grant     (grant),
    .port_id   (grant_port)
  );

  assign access_last = (state == ST_ACCESS) && (cnt == 4'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: fixed SETUP and DONE, ACCESS ends on counter terminal count.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (grant) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: if (access_last) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Grant latching, wait-state down-counter and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= 4'd0;
      lat_addr      <= '0;
      lat_port      <= PORT_DATA;
      lat_we        <= 1'b0;
      lat_wdata     <= '0;
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      if ((state == ST_IDLE) && grant) begin
        lat_port  <= grant_port;
        lat_addr  <= (grant_port == PORT_DATA) ? bus.data_addr : bus.fetch_addr;
        // The fetch port is read-only regardless of what data_we says.
        lat_we    <= (grant_port == PORT_DATA) && bus.data_we;
        lat_wdata <= bus.data_wdata;
      end
      if (state == ST_SETUP) begin
        cnt <= CNT_LOAD;
      end else if ((state == ST_ACCESS) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (access_last) begin
        if (lat_port == PORT_FETCH) begin
          fetch_rdata_q <= data;
        end else if (!lat_we) begin
          data_rdata_q <= data;
        end
      end
    end
  end

  // Strobe decode: only ACCESS pulls a strobe low, and exactly one chip at a time.
  always_comb begin
    ROM_CEb = 1'b1;
    RAM_CEb = 1'b1;
    RAM_WEb = 1'b1;
    RAM_OEb = 1'b1;
    if (state == ST_ACCESS) begin
      if (lat_port == PORT_FETCH) begin
        ROM_CEb = 1'b0;
      end else begin
        RAM_CEb = 1'b0;
        if (lat_we) begin
          RAM_WEb = 1'b0;
        end else begin
          RAM_OEb = 1'b0;
        end
      end
    end
  end

  // Write data covers SETUP through DONE so the RAM sees setup and hold around WEb.
  assign data_oe = lat_we && (state != ST_IDLE);
  assign data    = data_oe ? lat_wdata : 'z;
  assign address = lat_addr;

  assign bus.fetch_ack   = (state == ST_DONE) && (lat_port == PORT_FETCH);
  assign bus.data_ack    = (state == ST_DONE) && (lat_port == PORT_DATA);
  assign bus.fetch_rdata = fetch_rdata_q;
  assign bus.data_rdata  = data_rdata_q;

endmodule

// File: tb/tb_bf_mem_bus_ctrl.sv
// Directed bench for bf_mem_bus_ctrl: one instance with WAIT_CYCLES=1 (index 0)
// and one with WAIT_CYCLES=3 (index 1), each with a ROM/RAM model on its bus.
module tb_bf_mem_bus_ctrl;
  import bf_membus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  logic       f_req   [2];
  logic [3:0] f_addr  [2];
  logic       d_req   [2];
  logic       d_we    [2];
  logic [3:0] d_addr  [2];
  logic [7:0] d_wdata [2];

  wire       f_ack    [2];
  wire       d_ack    [2];
  wire [7:0] f_rdata  [2];
  wire [7:0] d_rdata  [2];
  wire [3:0] addr_bus [2];
  wire       rom_ceb  [2];
  wire       ram_ceb  [2];
  wire       ram_web  [2];
  wire       ram_oeb  [2];
  wire       oe       [2];
  wire [7:0] bus_in   [2];
  wire [7:0] data_bus1;
  wire [7:0] data_bus3;

  bf_mem_bus_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus1 ();
  bf_mem_bus_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus3 ();

  assign bus1.fetch_req  = f_req[0];
  assign bus1.fetch_addr = f_addr[0];
  assign bus1.data_req   = d_req[0];
  assign bus1.data_we    = d_we[0];
  assign bus1.data_addr  = d_addr[0];
  assign bus1.data_wdata = d_wdata[0];
  assign f_ack[0]        = bus1.fetch_ack;
  assign d_ack[0]        = bus1.data_ack;
  assign f_rdata[0]      = bus1.fetch_rdata;
  assign d_rdata[0]      = bus1.data_rdata;

  assign bus3.fetch_req  = f_req[1];
  assign bus3.fetch_addr = f_addr[1];
  assign bus3.data_req   = d_req[1];
  assign bus3.data_we    = d_we[1];
  assign bus3.data_addr  = d_addr[1];
  assign bus3.data_wdata = d_wdata[1];
  assign f_ack[1]        = bus3.fetch_ack;
  assign d_ack[1]        = bus3.data_ack;
  assign f_rdata[1]      = bus3.fetch_rdata;
  assign d_rdata[1]      = bus3.data_rdata;

  bf_mem_bus_ctrl #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(1)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus1),
    .address (addr_bus[0]),
    .data    (data_bus1),
    .ROM_CEb (rom_ceb[0]),
    .RAM_CEb (ram_ceb[0]),
    .RAM_WEb (ram_web[0]),
    .RAM_OEb (ram_oeb[0])
  );

  bf_mem_bus_ctrl #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(3)) dut3 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus3),
    .address (addr_bus[1]),
    .data    (data_bus3),
    .ROM_CEb (rom_ceb[1]),
    .RAM_CEb (ram_ceb[1]),
    .RAM_WEb (ram_web[1]),
    .RAM_OEb (ram_oeb[1])
  );

  assign oe[0]     = dut1.data_oe;
  assign oe[1]     = dut3.data_oe;
  assign bus_in[0] = data_bus1;
  assign bus_in[1] = data_bus3;

  // ROM shared by both instances, RAM per instance.
  logic [7:0] rom [16];
  logic [7:0] ram [2][16];
  logic       mem_en [2];
  logic [7:0] mem_q  [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      mem_en[i] = 1'b0;
      mem_q[i]  = 8'h00;
      if (!rom_ceb[i]) begin
        mem_en[i] = 1'b1;
        mem_q[i]  = rom[addr_bus[i]];
      end else if (!ram_ceb[i] && !ram_oeb[i]) begin
        mem_en[i] = 1'b1;
        mem_q[i]  = ram[i][addr_bus[i]];
      end
    end
  end

  assign data_bus1 = mem_en[0] ? mem_q[0] : 'z;
  assign data_bus3 = mem_en[1] ? mem_q[1] : 'z;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!ram_ceb[i] && !ram_web[i]) ram[i][addr_bus[i]] <= bus_in[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Strobe/drive cycle counters and per-cycle contention checks.
  int rom_low [2];
  int web_low [2];
  int oeb_low [2];
  int oe_hi   [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rom_ceb[i]) rom_low[i] <= rom_low[i] + 1;
      if (!ram_web[i]) web_low[i] <= web_low[i] + 1;
      if (!ram_oeb[i]) oeb_low[i] <= oeb_low[i] + 1;
      if (oe[i])       oe_hi[i]   <= oe_hi[i] + 1;
      chk("mon_both_ce_low", 32'(!rom_ceb[i] && !ram_ceb[i]), 32'd0);
      chk("mon_we_oe_low", 32'(!ram_web[i] && !ram_oeb[i]), 32'd0);
      chk("mon_drive_on_read", 32'(oe[i] && (!ram_oeb[i] || !rom_ceb[i])), 32'd0);
    end
  end

  // One complete access on instance i; lat counts negedges after the sampling edge.
  task automatic run_txn(input int i, input logic is_data, input logic we,
                         input logic [3:0] addr, input logic [7:0] wdata,
                         output int lat, output int stb, output int oec,
                         output logic [7:0] rdata);
    int  s0, o0;
    bit  got;
    @(posedge clk);
    #1;
    if (is_data) begin
      d_req[i] = 1'b1; d_we[i] = we; d_addr[i] = addr; d_wdata[i] = wdata;
    end else begin
      f_req[i] = 1'b1; f_addr[i] = addr;
    end
    @(posedge clk);
    s0  = is_data ? (we ? web_low[i] : oeb_low[i]) : rom_low[i];
    o0  = oe_hi[i];
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      got = is_data ? d_ack[i] : f_ack[i];
    end
    #1;
    if (!got) chk("txn_ack_timeout", 32'd0, 32'd1);
    f_req[i] = 1'b0;
    d_req[i] = 1'b0;
    stb   = (is_data ? (we ? web_low[i] : oeb_low[i]) : rom_low[i]) - s0;
    oec   = oe_hi[i] - o0;
    rdata = is_data ? d_rdata[i] : f_rdata[i];
  endtask

  typedef struct {
    logic       is_data;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    int         exp_oe;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat, stb, oec, t, td, tf, n, cnt_ack;
    logic [7:0] rd, last_fetch;
    logic       seq [4];
    logic       exp_seq [4];
    int         tim [4];

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      f_req[i] = 1'b0; f_addr[i] = 4'h0; d_req[i] = 1'b0;
      d_we[i] = 1'b0; d_addr[i] = 4'h0; d_wdata[i] = 8'h00;
    end
    for (int a = 0; a < 16; a++) rom[a] = 8'h00;
    rom[0]  = 8'h11;
    rom[3]  = 8'hA5;
    rom[15] = 8'hF0;

    //         is_data we   addr   wdata  exp_rd oe
    vecs[0] = '{1'b0, 1'b0, 4'h3, 8'h00, 8'hA5, 0};
    vecs[1] = '{1'b0, 1'b0, 4'h0, 8'h00, 8'h11, 0};
    vecs[2] = '{1'b0, 1'b0, 4'hF, 8'h00, 8'hF0, 0};
    vecs[3] = '{1'b1, 1'b1, 4'h2, 8'h3C, 8'h00, 3};
    vecs[4] = '{1'b1, 1'b1, 4'hF, 8'hC3, 8'h00, 3};
    vecs[5] = '{1'b1, 1'b0, 4'h2, 8'h00, 8'h3C, 0};
    vecs[6] = '{1'b1, 1'b0, 4'hF, 8'h00, 8'hC3, 0};
    vecs[7] = '{1'b1, 1'b1, 4'h2, 8'h96, 8'h00, 3};
    vecs[8] = '{1'b1, 1'b0, 4'h2, 8'h00, 8'h96, 0};

    // Reset state on both instances.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst0_rom_ceb", 32'(rom_ceb[i]), 32'd1);
      chk("rst0_ram_ceb", 32'(ram_ceb[i]), 32'd1);
      chk("rst0_ram_web", 32'(ram_web[i]), 32'd1);
      chk("rst0_ram_oeb", 32'(ram_oeb[i]), 32'd1);
      chk("rst0_drive", 32'(oe[i]), 32'd0);
      chk("rst0_acks", 32'({f_ack[i], d_ack[i]}), 32'd0);
      chk("rst0_address", 32'(addr_bus[i]), 32'd0);
      chk("rst0_rdata", 32'({f_rdata[i], d_rdata[i]}), 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // Vector table on the WAIT_CYCLES=1 instance.
    last_fetch = 8'h00;
    for (int v = 0; v < 9; v++) begin
      run_txn(0, vecs[v].is_data, vecs[v].we, vecs[v].addr, vecs[v].wdata, lat, stb, oec, rd);
      chk("vec_latency", 32'(lat), 32'd3);
      chk("vec_strobe_cycles", 32'(stb), 32'd1);
      chk("vec_drive_cycles", 32'(oec), 32'(vecs[v].exp_oe));
      if (vecs[v].is_data && vecs[v].we) begin
        chk("vec_ram_write", 32'(ram[0][vecs[v].addr]), 32'(vecs[v].wdata));
      end else begin
        chk("vec_rdata", 32'(rd), 32'(vecs[v].exp_rdata));
      end
      if (vecs[v].is_data) begin
        chk("vec_fetch_hold", 32'(f_rdata[0]), 32'(last_fetch));
      end else begin
        last_fetch = vecs[v].exp_rdata;
      end
    end

    // Reset in the middle of a write's ACCESS cycle.
    @(posedge clk);
    #1;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 4'h5; d_wdata[0] = 8'h77;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_in_access", 32'(ram_web[0]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_rom_ceb", 32'(rom_ceb[0]), 32'd1);
    chk("rstmid_ram_ceb", 32'(ram_ceb[0]), 32'd1);
    chk("rstmid_ram_web", 32'(ram_web[0]), 32'd1);
    chk("rstmid_ram_oeb", 32'(ram_oeb[0]), 32'd1);
    chk("rstmid_drive", 32'(oe[0]), 32'd0);
    chk("rstmid_data_ack", 32'(d_ack[0]), 32'd0);
    chk("rstmid_state", 32'(dut1.state), 32'(ST_IDLE));
    chk("rstmid_address", 32'(addr_bus[0]), 32'd0);
    chk("rstmid_rdata", 32'({f_rdata[0], d_rdata[0]}), 32'd0);
    rst = 1'b0;
    d_req[0] = 1'b0;
    cnt_ack = 0;
    repeat (6) begin
      @(negedge clk);
      if (d_ack[0] || f_ack[0]) cnt_ack++;
    end
    chk("rstmid_no_late_ack", 32'(cnt_ack), 32'd0);

    // Simultaneous requests from IDLE.
    @(posedge clk);
    #1;
    f_req[0] = 1'b1; f_addr[0] = 4'h3;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 4'h2;
    t = 0; td = -1; tf = -1;
    while ((td < 0 || tf < 0) && t < 40) begin
      @(negedge clk);
      t++;
      if (d_ack[0]) begin td = t; #1 d_req[0] = 1'b0; end
      if (f_ack[0]) begin tf = t; #1 f_req[0] = 1'b0; end
    end
    f_req[0] = 1'b0;
    d_req[0] = 1'b0;
    chk("sim_data_ack_time", 32'(td), 32'd4);
    chk("sim_fetch_ack_time", 32'(tf), 32'd8);
    chk("sim_data_rdata", 32'(d_rdata[0]), 32'h96);
    chk("sim_fetch_rdata", 32'(f_rdata[0]), 32'hA5);

    // Continuous requests on both ports.
`ifdef MEMBUS_ROUND_ROBIN_EN
    exp_seq = '{PORT_DATA, PORT_FETCH, PORT_DATA, PORT_FETCH};
`else
    exp_seq = '{PORT_DATA, PORT_DATA, PORT_DATA, PORT_DATA};
`endif
    @(posedge clk);
    #1;
    f_req[0] = 1'b1; f_addr[0] = 4'hF;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 4'h2;
    n = 0; t = 0;
    while (n < 4 && t < 60) begin
      @(negedge clk);
      t++;
      if (d_ack[0]) begin seq[n] = PORT_DATA; tim[n] = t; n++; end
      else if (f_ack[0]) begin seq[n] = PORT_FETCH; tim[n] = t; n++; end
    end
    #1;
    f_req[0] = 1'b0;
    d_req[0] = 1'b0;
    chk("rr_ack_count", 32'(n), 32'd4);
    for (int k = 0; k < n; k++) begin
      chk("rr_order", 32'(seq[k]), 32'(exp_seq[k]));
      chk("rr_ack_time", 32'(tim[k]), 32'(4 + 4 * k));
    end

    // WAIT_CYCLES=3: write, read back, fetch.
    run_txn(1, 1'b1, 1'b1, 4'hE, 8'h5C, lat, stb, oec, rd);
    chk("w3_write_latency", 32'(lat), 32'd5);
    chk("w3_web_cycles", 32'(stb), 32'd3);
    chk("w3_write_drive", 32'(oec), 32'd5);
    chk("w3_ram_write", 32'(ram[1][14]), 32'h5C);
    run_txn(1, 1'b1, 1'b0, 4'hE, 8'h00, lat, stb, oec, rd);
    chk("w3_read_latency", 32'(lat), 32'd5);
    chk("w3_oeb_cycles", 32'(stb), 32'd3);
    chk("w3_read_drive", 32'(oec), 32'd0);
    chk("w3_read_rdata", 32'(rd), 32'h5C);
    run_txn(1, 1'b0, 1'b0, 4'h3, 8'h00, lat, stb, oec, rd);
    chk("w3_fetch_latency", 32'(lat), 32'd5);
    chk("w3_rom_cycles", 32'(stb), 32'd3);
    chk("w3_fetch_rdata", 32'(rd), 32'hA5);
    chk("w3_data_rdata_hold", 32'(d_rdata[1]), 32'h5C);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bf_mem_bus_ctrl.md
# bf_mem_bus_ctrl

Single-clock bus controller sitting between the BrainFuzz interpreter core and the shared ROM/RAM chip bus. It accepts independent program-fetch (ROM read) and data (RAM read/write) requests, arbitrates them, and sequences the chips' active-low strobes and the shared bidirectional data bus. It is generalised in address/data width and wait states and guarantees no bus contention. It replaces testbench-driven strobe manipulation with a cycle-accurate, request/acknowledge-driven engine.

## Interface
- ADDR_W, 4: width of `address`, `fetch_addr`, `data_addr`.
- DATA_W, 8: width of `data` bus and all data ports.
- WAIT_CYCLES, 1: strobe-active cycles per access; legal range 1..15.

- clk  in  1  single clock; everything samples on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  ROM read request; held until `fetch_ack`.
- fetch_addr  in  ADDR_W  ROM address, latched at grant.
- fetch_ack  out  1  one-cycle completion pulse.
- fetch_rdata  out  DATA_W  ROM data, valid from the `fetch_ack` cycle until the next fetch completes.
- data_req  in  1  RAM request; held until `data_ack`.
- data_we  in  1  1 = write, 0 = read; latched at grant.
- data_addr  in  ADDR_W  RAM address, latched at grant.
- data_wdata  in  DATA_W  write data, latched at grant.
- data_ack  out  1  one-cycle completion pulse.
- data_rdata  out  DATA_W  RAM read data, valid from the `data_ack` cycle until the next data read completes.
- address  out  ADDR_W  shared chip address bus.
- data  inout  DATA_W  shared chip data bus; controller drives it only during RAM writes, otherwise hi-Z.
- ROM_CEb, RAM_CEb, RAM_WEb, RAM_OEb  out  1 each  active-low chip strobes.

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE: if any request is high, the arbiter grants one port. On grant, latch the address, the port ID, `we` and `wdata`, and move to SETUP.
- SETUP (1 cycle): `address` is driven. All strobes stay high. For a write, `data` becomes driven.
- ACCESS (WAIT_CYCLES cycles, counted by a 4-bit counter):
  - Fetch: ROM_CEb=0.
  - RAM read: RAM_CEb=0, RAM_OEb=0.
  - RAM write: RAM_CEb=0, RAM_WEb=0, `data` driven.
  - Read data is captured into the port's rdata register at the edge that ends the last ACCESS cycle.
- DONE (1 cycle): all strobes are high. The granted port's ack is 1. A write keeps `data` and `address` driven for hold time. The FSM then returns to IDLE.
- Arbitration (default): fixed priority, data over fetch.
- The fetch port never writes. The data port never touches the ROM.
- A request that drops before its ack is a protocol violation, and the access completes anyway.
- Never assert ROM_CEb and RAM_CEb low together. Never assert RAM_WEb and RAM_OEb low together. `data` is driven only while a write is in SETUP, ACCESS or DONE.

## Timing
- Request sampled high in IDLE at edge N:
  - SETUP during cycle N+1.
  - ACCESS during cycles N+2 .. N+1+WAIT_CYCLES.
  - Ack high during cycle N+2+WAIT_CYCLES.
- Latency from request to ack is 2+WAIT_CYCLES cycles. Back-to-back throughput is one access per 3+WAIT_CYCLES cycles.
- A request still high in the ack cycle is treated as a new request in the next IDLE. Requesters must drop it in the ack cycle unless they issue a follow-on access.
- Simultaneous requests in IDLE: one grant only. The loser waits and keeps its request held.
- Reset values (apply from the edge where `rst` is sampled high, including mid-access):
  - State IDLE, counter 0.
  - All strobes 1, `data` hi-Z, `address` 0.
  - Both acks 0, both rdata registers 0.
  - Round-robin pointer set to data.
  - An in-flight access is abandoned with no ack.

## Configuration
- MEMBUS_ROUND_ROBIN_EN defined: round-robin arbitration. On a tie, the port not granted last wins, so alternating simultaneous requests are served data, fetch, data, …
- Not defined: fixed data-over-fetch priority. The pointer register is not built.

## Structure
- Shared package `bf_membus_pkg`: FSM state encoding, port ID constants (PORT_FETCH, PORT_DATA), and the WAIT_CYCLES range limit.
- Sub-module `bf_membus_arb`: a two-requester arbiter. It holds the `ifdef`, outputs the grant and port ID, and takes `clk`/`rst` for the round-robin pointer.

## Test plan
- Reset test, WAIT_CYCLES=1: assert `rst` in the middle of a RAM write's ACCESS cycle. Next cycle: all strobes 1, `data` hi-Z, no `data_ack`, state IDLE.
- Fetch timing: ROM preloaded with 8'hA5 at 4'h3. `fetch_req` at edge N → ROM_CEb low in cycle N+2 only, `fetch_ack` in N+3, `fetch_rdata`=8'hA5.
- Write then read, WAIT_CYCLES=3: write 8'h5C to RAM 4'hE → RAM_WEb low for exactly 3 cycles, `data_ack` at N+5. A following read of 4'hE → `data_rdata`=8'h5C, RAM_OEb low for 3 cycles.
- Simultaneous requests in IDLE, macro off: `data_ack` first, `fetch_ack` 4 cycles later (WAIT_CYCLES=1).
- Continuous requests on both ports, macro on: grants alternate data, fetch, data, fetch.
- Contention monitor, checked every cycle across all tests: both CEb low never occurs, WEb and OEb low together never occurs, and `data` is never driven while RAM_OEb or ROM_CEb is low.
